// File: rtl/operand_stack_if.sv
// Command and status bundle between the tinycpu control unit and the operand stack.
// The master issues push/pop/load commands; the slave returns the top entries and flags.
interface operand_stack_if #(
    parameter int WIDTH = 16,
    parameter int PW    = 4
);
    logic             push;
    logic             pop;
    logic             load;
    logic [WIDTH-1:0] d;
    logic             err_clr;
    logic [WIDTH-1:0] qtop;
    logic [WIDTH-1:0] qnext;
    logic [PW:0]      depth;
    logic             empty;
    logic             full;
    logic             err;

    modport master (
        output push, pop, load, d, err_clr,
        input  qtop, qnext, depth, empty, full, err
    );

    modport slave (
        input  push, pop, load, d, err_clr,
        output qtop, qnext, depth, empty, full, err
    );
endinterface

// File: rtl/operand_stack.sv
// Evaluation stack feeding the ALU: top entry drives operand a, next entry drives operand b.
// Rejected commands leave the state untouched and raise a sticky err flag.
module operand_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int PW    = 4
) (
    input logic            clk,
    input logic            reset,
    operand_stack_if.slave bus
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      sp;
    logic [PW:0]      sp_next;
    logic [PW-1:0]    top_idx;
    logic [PW-1:0]    next_idx;
    logic [PW-1:0]    wr_idx;
    logic             wr_en;
    logic             err_set;
    logic             err_q;
    logic             has_one;
    logic             has_two;
    logic             is_full;

    // Modular index math: at sp == DEPTH the low bits are 0, so top wraps to DEPTH-1.
    assign top_idx  = sp[PW-1:0] - PW'(1);
    assign next_idx = sp[PW-1:0] - PW'(2);
    assign has_one  = (sp != '0);
    assign has_two  = (sp >= (PW+1)'(2));
    assign is_full  = (sp == (PW+1)'(DEPTH));

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = top_idx;
        sp_next = sp;
        err_set = 1'b0;
        unique case ({bus.push, bus.pop, bus.load})
            3'b000: begin
            end
            3'b100: begin
                if (is_full) begin
                    err_set = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    wr_idx  = sp[PW-1:0];
                    sp_next = sp + (PW+1)'(1);
                end
            end
            3'b010: begin
                if (!has_one) err_set = 1'b1;
                else          sp_next = sp - (PW+1)'(1);
            end
            3'b001: begin
                if (!has_one) err_set = 1'b1;
                else          wr_en   = 1'b1;
            end
            3'b011: begin
                // Binary op: result overwrites operand b and operand a is dropped.
                if (!has_two) begin
                    err_set = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    wr_idx  = next_idx;
                    sp_next = sp - (PW+1)'(1);
                end
            end
            default: err_set = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp    <= '0;
            err_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            sp <= sp_next;
            if (wr_en) begin
                mem[wr_idx] <= bus.d;
            end
            if (err_set) begin
                err_q <= 1'b1;
            end else if (bus.err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    assign bus.qtop  = has_one ? mem[top_idx] : '0;
    assign bus.qnext = has_two ? mem[next_idx] : '0;
    assign bus.depth = sp;
    assign bus.empty = !has_one;
    assign bus.full  = is_full;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_operand_stack.sv
// Scoreboard bench for operand_stack: a queue-based stack model predicts every
// cycle's outputs, which are queued at drive time and popped after the clock edge.
module tb_operand_stack;
    typedef logic [39:0] obs_t;

    logic clk;
    logic reset;
    int   checks;
    int   passed;
    obs_t sb [$];
    logic [15:0] model [$];
    logic merr;

    operand_stack_if #(.WIDTH(16), .PW(4)) bus ();

    operand_stack #(.WIDTH(16), .DEPTH(16), .PW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t predict();
        logic [15:0] t;
        logic [15:0] n;
        int sz;
        sz = model.size();
        t = (sz >= 1) ? model[sz-1] : 16'h0;
        n = (sz >= 2) ? model[sz-2] : 16'h0;
        return {5'(sz), t, n, merr, sz == 0, sz == 16};
    endfunction

    function automatic obs_t observe();
        return {bus.depth, bus.qtop, bus.qnext, bus.err, bus.empty, bus.full};
    endfunction

    task automatic step(input bit p, input bit o, input bit l,
                        input bit c, input logic [15:0] dv);
        bit e;
        @(negedge clk);
        bus.push = p; bus.pop = o; bus.load = l;
        bus.err_clr = c; bus.d = dv;
        e = 1'b0;
        unique case ({p, o, l})
            3'b000: ;
            3'b100: if (model.size() == 16) e = 1; else model.push_back(dv);
            3'b010: if (model.size() == 0) e = 1; else void'(model.pop_back());
            3'b001: if (model.size() == 0) e = 1; else model[model.size()-1] = dv;
            3'b011: begin
                if (model.size() < 2) e = 1;
                else begin
                    void'(model.pop_back());
                    model[model.size()-1] = dv;
                end
            end
            default: e = 1;
        endcase
        if (e) merr = 1'b1;
        else if (c) merr = 1'b0;
        sb.push_back(predict());
        @(posedge clk);
        #1;
        bus.push = 0; bus.pop = 0; bus.load = 0; bus.err_clr = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        model.delete();
        merr = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        obs_t e;
        obs_t o;
        reset = 1'b1;
        model.delete();
        merr = 1'b0;
        #1;
        sb.push_back(predict());
        e = sb.pop_front(); o = observe(); checks++;
        if (o !== e) $display("FAIL reset_init: got %h want %h", o, e);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 0, 16'h0100 + 16'(i));
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) $display("FAIL reset_fill%0d: got %h want %h", i, o, e);
            else passed++;
        end
        // Mid-cycle assertion, away from any clock edge.
        #2;
        reset = 1'b1;
        model.delete();
        merr = 1'b0;
        #1;
        sb.push_back(predict());
        e = sb.pop_front(); o = observe(); checks++;
        if (o !== e) $display("FAIL reset_async: got %h want %h", o, e);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_binary();
        obs_t e;
        obs_t o;
        logic [16:0] c [3] = '{17'h10003, 17'h10005, 17'h00008};
        for (int i = 0; i < 3; i++) begin
            if (c[i][16]) step(1, 0, 0, 0, c[i][15:0]);
            else          step(0, 1, 1, 0, c[i][15:0]);
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) $display("FAIL binary%0d: got %h want %h", i, o, e);
            else passed++;
        end
        if (o !== {5'd1, 16'h0008, 16'h0000, 3'b000}) begin
            checks++;
            $display("FAIL binary_abs: got %h want %h", o,
                     {5'd1, 16'h0008, 16'h0000, 3'b000});
        end else begin
            checks++; passed++;
        end
    endtask

    task automatic test_replace_pop();
        obs_t e;
        obs_t o;
        logic [18:0] c [6] = '{
            {3'b100, 16'h1234}, {3'b001, 16'hEDCB}, {3'b010, 16'h0},
            {3'b010, 16'h0},    {3'b010, 16'h0},    {3'b000, 16'h0}
        };
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            step(c[i][18], c[i][17], c[i][16], i == 5, c[i][15:0]);
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) $display("FAIL replace_pop%0d: got %h want %h", i, o, e);
            else passed++;
        end
    endtask

    task automatic test_full();
        obs_t e;
        obs_t o;
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 0, 0, 16'(i));
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) $display("FAIL full_push%0d: got %h want %h", i, o, e);
            else passed++;
        end
        step(1, 0, 0, 0, 16'hFFFF);
        e = sb.pop_front(); o = observe(); checks++;
        if (o !== e) $display("FAIL full_overflow: got %h want %h", o, e);
        else passed++;
        step(0, 0, 0, 1, 16'h0);
        e = sb.pop_front(); o = observe(); checks++;
        if (o !== e) $display("FAIL full_clr: got %h want %h", o, e);
        else passed++;
        // Drain and confirm the rejected push did not disturb storage.
        for (int i = 15; i >= 0; i--) begin
            step(0, 1, 0, 0, 16'h0);
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) $display("FAIL full_drain%0d: got %h want %h", i, o, e);
            else passed++;
        end
    endtask

    task automatic test_errors();
        obs_t e;
        obs_t o;
        logic [19:0] c [9] = '{
            {4'b1000, 16'h00AA}, {4'b0110, 16'h1111}, {4'b0001, 16'h0},
            {4'b1000, 16'h00BB}, {4'b1000, 16'h00CC}, {4'b1100, 16'h7777},
            {4'b1011, 16'h5555}, {4'b1110, 16'h6666}, {4'b0011, 16'h2222}
        };
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            step(c[i][19], c[i][18], c[i][17], c[i][16], c[i][15:0]);
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) $display("FAIL errors%0d: got %h want %h", i, o, e);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        obs_t e;
        obs_t o;
        logic [19:0] c [7] = '{
            {4'b1001, 16'hFFFF}, {4'b1001, 16'hFFFE}, {4'b0100, 16'h0},
            {4'b1001, 16'hABCD}, {4'b0110, 16'h4242}, {4'b0110, 16'h9999},
            {4'b0010, 16'h3333}
        };
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 0, 0, 16'hA000 + 16'(i * 3));
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) $display("FAIL b2b_fill%0d: got %h want %h", i, o, e);
            else passed++;
        end
        for (int i = 0; i < 7; i++) begin
            step(c[i][19], c[i][18], c[i][17], c[i][16], c[i][15:0]);
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) $display("FAIL b2b%0d: got %h want %h", i, o, e);
            else passed++;
        end
    endtask

    initial begin
        checks = 0;
        passed = 0;
        merr = 1'b0;
        reset = 1'b0;
        bus.push = 0; bus.pop = 0; bus.load = 0;
        bus.err_clr = 0; bus.d = '0;
        test_reset();
        test_binary();
        test_replace_pop();
        test_full();
        test_errors();
        test_back_to_back();
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL scoreboard_leftover: got %0d want 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/operand_stack.md
Name: operand_stack

Overview:
- Hardware operand stack for the tinycpu datapath; sits directly upstream of the ALU.
- Holds evaluation-stack data. Presents the top entry as the ALU "a" operand and the next entry as the ALU "b" operand.
- Accepts ALU results, immediates and memory loads for push, replace-top and binary-op commit.
- Its outputs are registered state, so ALU inputs are stable for the whole cycle.

Parameters:
- WIDTH, 16, data width; must match the ALU operand width.
- DEPTH, 16, number of entries; power of two, at least 4.
- PW, 4, pointer width, log2(DEPTH).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- push  input  1  push d onto the stack
- pop  input  1  remove the top entry
- load  input  1  write d into the top position (after the pop, if pop is also asserted)
- d  input  WIDTH  write data: ALU result, immediate, or memory read
- err_clr  input  1  clears the sticky err flag
- qtop  output  WIDTH  top entry; feeds ALU a
- qnext  output  WIDTH  second entry; feeds ALU b
- depth  output  PW+1  entry count, 0..DEPTH
- empty  output  1  depth == 0
- full  output  1  depth == DEPTH
- err  output  1  sticky overflow/underflow/illegal-command flag

Behaviour:
- Reset:
  - Asynchronous and active-high. Takes effect immediately, including mid-operation.
  - depth=0, err=0, all storage entries=0.
  - Hence qtop=0, qnext=0, empty=1, full=0.
- Storage: array mem[0..DEPTH-1] plus sp = depth. Top entry is mem[sp-1]; next entry is mem[sp-2].
- qtop = mem[sp-1] when depth>=1, else 0. qnext = mem[sp-2] when depth>=2, else 0. Both are combinational from registered state; the ALU sees them in the same cycle.
- All commands are sampled on the rising clk edge. Effects are visible after that edge, so there is one cycle of latency from command to new qtop/qnext.
- Legal commands ({push,pop,load}):
  - 000 idle: no change.
  - 100 push: mem[sp]<=d, depth+1. Requires !full.
  - 010 pop: depth-1. Requires depth>=1. The vacated entry is left unchanged.
  - 001 replace: mem[sp-1]<=d, depth unchanged. Requires depth>=1. Used for unary ALU ops such as NEG, BNOT, NOT.
  - 011 binary commit: mem[sp-2]<=d, depth-1. Requires depth>=2. In the same cycle the ALU consumes qtop/qnext and returns s on d, so a binary ALU op completes in one cycle.
- Error cases (state unchanged, err<=1):
  - Any of: push when full; pop or replace when depth==0; binary commit when depth<2.
  - Any illegal combination: 110, 101, 111.
- err is sticky. err_clr=1 clears it at the edge.
  - If err_clr and a new error occur in the same cycle, the error wins and err=1.
  - err_clr does not block a legal command in the same cycle.
- Width rules:
  - d is stored unmodified.
  - depth is PW+1 bits, so DEPTH itself is representable; no wrap-around is possible because overflowing commands are rejected.
- Boundaries:
  - Push at depth DEPTH-1 leads to full=1.
  - A binary commit at depth 2 yields depth 1 with qnext=0.
  - Pop to empty leads to qtop=0.

Test Plan:
- Assert reset mid-stream with depth=5 -> outputs take reset values (depth=0, qtop=0, empty=1, err=0) immediately, without waiting for a clock edge.
- Push 0x0003 then 0x0005 -> depth=2, qtop=0x0005, qnext=0x0003. Binary commit with d=0x0008 (ALU ADD result) -> depth=1, qtop=0x0008, qnext=0.
- Push 0x1234 then replace with d=0xEDCB -> depth=1, qtop=0xEDCB. Pop -> empty=1, qtop=0. Pop again -> err=1, depth stays 0.
- Push 16 values 0x0000..0x000F -> full=1, qtop=0x000F, qnext=0x000E. A 17th push of 0xFFFF -> err=1 and storage unchanged. err_clr -> err=0.
- With depth=1, binary commit -> err=1, qtop unchanged. Command 110 at depth 3 -> err=1, depth stays 3.
- Same-cycle err_clr with a push on a full stack -> err stays 1. err_clr with a legal push -> push takes effect and err=0.
